// File: rtl/multi7seg_capture.sv
// multi7seg_capture: rebuilds four hex digits from a scanned,
// active-low 7-segment bus (segment) and one-hot digit strobes (ground).
// Ports: clock, reset_n (async, active-low); segment[7:0] (bit7 = DP),
//        ground[3:0]; data0..data3 digit values; digit_valid, dp,
//        seg_error per-digit flags; frame_done one-cycle frame pulse.
// Option: define MULTI7SEG_CAPTURE_SYNC_EN to put a 2-flop synchroniser
//         on segment/ground (adds 2 edges of latency).
module multi7seg_capture #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [7:0] segment,
   input  logic [3:0] ground,
   output logic [3:0] data0,
   output logic [3:0] data1,
   output logic [3:0] data2,
   output logic [3:0] data3,
   output logic [3:0] digit_valid,
   output logic [3:0] dp,
   output logic [3:0] seg_error,
   output logic       frame_done
);

   localparam logic [7:0] RUN_MAX = 8'(STABLE_CYCLES);
   localparam logic [7:0] RUN_HIT = 8'(STABLE_CYCLES - 1);

   logic [11:0] w_in;

`ifdef MULTI7SEG_CAPTURE_SYNC_EN
   logic [11:0] r_sync1;
   logic [11:0] r_sync2;

   // Synchroniser flops idle at 1 (segments dark, no strobe).
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= '1;
         r_sync2 <= '1;
      end else begin
         r_sync1 <= {ground, segment};
         r_sync2 <= r_sync1;
      end
   end

   assign w_in = r_sync2;
`else
   assign w_in = {ground, segment};
`endif

   logic [11:0]      r_s;
   logic [7:0]       r_run;
   logic [3:0][3:0]  r_data;
   logic [3:0]       r_valid;
   logic [3:0]       r_dp;
   logic [3:0]       r_err;
   logic [3:0]       r_mask;
   logic             r_frame;

   logic             w_same;
   logic             w_commit;
   logic [3:0]       w_gnd;
   logic [6:0]       w_glyph;
   logic             w_dp_lit;
   logic             w_dig_ok;
   logic [1:0]       w_dig;
   logic [3:0]       w_bit;
   logic             w_known;
   logic             w_blank;
   logic [3:0]       w_val;

   assign w_same   = (w_in == r_s);
   // Fires once per stable period: the run counter saturates
   // at STABLE_CYCLES, so it passes RUN_HIT only once.
   assign w_commit = w_same && (r_run == RUN_HIT);
   assign w_gnd    = w_in[11:8];
   assign w_dp_lit = ~w_in[7];
   assign w_glyph  = w_in[6:0];
   assign w_bit    = 4'b0001 << w_dig;

   always_comb begin
      w_dig_ok = 1'b1;
      w_dig    = 2'd0;
      unique case (w_gnd)
         4'b0111: w_dig = 2'd0;
         4'b1011: w_dig = 2'd1;
         4'b1101: w_dig = 2'd2;
         4'b1110: w_dig = 2'd3;
         default: w_dig_ok = 1'b0;
      endcase
   end

   always_comb begin
      w_known = 1'b1;
      w_blank = 1'b0;
      w_val   = 4'h0;
      unique case (w_glyph)
         7'h40: w_val = 4'h0;
         7'h79: w_val = 4'h1;
         7'h24: w_val = 4'h2;
         7'h30: w_val = 4'h3;
         7'h19: w_val = 4'h4;
         7'h12: w_val = 4'h5;
         7'h02: w_val = 4'h6;
         7'h78: w_val = 4'h7;
         7'h00: w_val = 4'h8;
         7'h10: w_val = 4'h9;
         7'h08: w_val = 4'hA;
         7'h03: w_val = 4'hB;
         7'h46: w_val = 4'hC;
         7'h21: w_val = 4'hD;
         7'h06: w_val = 4'hE;
         7'h0E: w_val = 4'hF;
         7'h7F: begin
            w_known = 1'b0;
            w_blank = 1'b1;
         end
         default: w_known = 1'b0;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_s     <= 12'hFFF;
         r_run   <= 8'd0;
         r_data  <= '0;
         r_valid <= 4'b0;
         r_dp    <= 4'b0;
         r_err   <= 4'b0;
         r_mask  <= 4'b0;
         r_frame <= 1'b0;
      end else begin
         r_s     <= w_in;
         r_frame <= 1'b0;
         if (!w_same)
            r_run <= 8'd1;
         else if (r_run < RUN_MAX)
            r_run <= r_run + 8'd1;

         if (w_commit && w_dig_ok) begin
            r_dp[w_dig] <= w_dp_lit;
            if (w_known) begin
               r_data[w_dig]  <= w_val;
               r_valid[w_dig] <= 1'b1;
               r_err[w_dig]   <= 1'b0;
            end else if (w_blank) begin
               r_valid[w_dig] <= 1'b0;
            end else begin
               r_err[w_dig]   <= 1'b1;
            end

            if ((r_mask | w_bit) == 4'hF) begin
               r_frame <= 1'b1;
               r_mask  <= 4'b0;
            end else begin
               r_mask  <= r_mask | w_bit;
            end
         end
      end
   end

   assign data0       = r_data[0];
   assign data1       = r_data[1];
   assign data2       = r_data[2];
   assign data3       = r_data[3];
   assign digit_valid = r_valid;
   assign dp          = r_dp;
   assign seg_error   = r_err;
   assign frame_done  = r_frame;

endmodule
